// File: rtl/axis_phit_framer.sv
// AXI-Stream phit framer: FWFT FIFO that re-emits the input stream as fixed-length packets,
// closing a packet early on input tlast, with packet and early-termination counters.
module axis_phit_framer #(
  parameter int unsigned PHIT_SIZE  = 512,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [LEN_W-1:0]              cfg_pkt_len,
  input  logic [PHIT_SIZE-1:0]          s_axis_tdata,
  input  logic [PHIT_SIZE/8-1:0]        s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [PHIT_SIZE-1:0]          m_axis_tdata,
  output logic [PHIT_SIZE/8-1:0]        m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              pkt_count,
  output logic [CNT_W-1:0]              early_term_count
);

  localparam int unsigned KEEP_W = PHIT_SIZE / 8;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W  = PHIT_SIZE + KEEP_W + 1;

  typedef enum logic {S_IDLE, S_BODY} state_t;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_in_rdy;
  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic [CNT_W-1:0]  r_early_cnt;

  logic [AW:0]       w_level;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [ENT_W-1:0]  w_head;
  logic              w_head_last;
  logic [LEN_W-1:0]  w_cfg_len;
  logic [LEN_W-1:0]  w_len_eff;
  logic              w_at_len;
  logic              w_is_last;
  state_t            w_state_nxt;
  logic [LEN_W-1:0]  w_len_nxt;
  logic [LEN_W-1:0]  w_beat_nxt;
  logic [CNT_W-1:0]  w_pkt_nxt;
  logic [CNT_W-1:0]  w_early_nxt;

  assign w_level     = r_wr_ptr - r_rd_ptr;
  assign w_full      = (w_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty     = (w_level == '0);
  assign w_push      = s_axis_tvalid && s_axis_tready;
  assign w_pop       = m_axis_tvalid && m_axis_tready;
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_last = w_head[0];

  // Ready is held low through reset and comes up on the first edge after release.
  assign s_axis_tready = r_in_rdy && !w_full;
  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? '0 : w_head[ENT_W-1 -: PHIT_SIZE];
  assign m_axis_tkeep  = w_empty ? '0 : w_head[KEEP_W:1];
  assign m_axis_tlast  = !w_empty && w_is_last;
  assign fifo_level    = w_level;
  assign pkt_count     = r_pkt_cnt;
  assign early_term_count = r_early_cnt;

  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_in_rdy <= 1'b0;
    end else begin
      r_in_rdy <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Framing state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_early_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_pkt_cnt   <= w_pkt_nxt;
      r_early_cnt <= w_early_nxt;
    end
  end

  // Length is taken from cfg while idle so the first beat already sees the new value.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_beat_nxt  = r_beat_cnt;
    w_pkt_nxt   = r_pkt_cnt;
    w_early_nxt = r_early_cnt;
    w_cfg_len   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
    w_len_eff   = (r_state == S_BODY) ? r_len : w_cfg_len;
    w_at_len    = (r_beat_cnt == (w_len_eff - LEN_W'(1)));
    w_is_last   = w_at_len || w_head_last;
    if (w_pop) begin
      if (r_state == S_IDLE) w_len_nxt = w_cfg_len;
      if (w_is_last) begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = '0;
        w_pkt_nxt   = r_pkt_cnt + CNT_W'(1);
        if (w_head_last && !w_at_len) w_early_nxt = r_early_cnt + CNT_W'(1);
      end else begin
        w_state_nxt = S_BODY;
        w_beat_nxt  = r_beat_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: doc/axis_phit_framer.md
Name: axis_phit_framer

Overview:
- Sits directly downstream of the stream-in emulator. Consumes its raw phit stream on axis00 and buffers it in an internal FIFO.
- Re-emits the data as fixed-length packets toward the CGRA input port. tlast is regenerated every cfg_pkt_len beats, or earlier when the input marks an early end.
- Decouples emulator burst timing from CGRA backpressure and reports per-packet status.

Parameters:
- PHIT_SIZE, 512: data width in bits. tkeep width is PHIT_SIZE/8.
- FIFO_DEPTH, 16: buffer entries. Must be a power of 2, at least 2.
- LEN_W, 8: width of the packet-length configuration and the beat counter.
- CNT_W, 32: width of the packet counter.

Ports:
- ap_clk, in, 1: sole clock. Everything is on its rising edge.
- ap_rst, in, 1: asynchronous, active-high reset.
- cfg_pkt_len, in, LEN_W: packet length in beats. Value 0 is treated as 1. Sampled only at packet start.
- s_axis_tdata, in, PHIT_SIZE: input phit.
- s_axis_tkeep, in, PHIT_SIZE/8: input byte enables. Stored with the phit.
- s_axis_tvalid, in, 1: input valid.
- s_axis_tlast, in, 1: input early end-of-packet.
- s_axis_tready, out, 1: input ready. Equals !fifo_full.
- m_axis_tdata, out, PHIT_SIZE: output phit.
- m_axis_tkeep, out, PHIT_SIZE/8: output byte enables.
- m_axis_tvalid, out, 1: output valid. Equals !fifo_empty.
- m_axis_tlast, out, 1: regenerated end-of-packet.
- m_axis_tready, in, 1: downstream ready.
- fifo_level, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- pkt_count, out, CNT_W: packets completed on the output.
- early_term_count, out, CNT_W: packets closed by input tlast before reaching the configured length.

Behaviour:
Reset (asserting ap_rst immediately forces the following, whatever operation is in progress):
- FIFO empties: pointers = 0, fifo_level = 0.
- s_axis_tready = 0 while ap_rst is asserted; it goes to 1 on the first edge after release.
- m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0.
- Beat counter = 0, FSM = IDLE, both counters = 0.
- A partially sent packet is discarded. No tlast is emitted for it.

FIFO:
- Push when s_axis_tvalid && s_axis_tready. Each entry holds {tdata, tkeep, tlast}.
- Pop when m_axis_tvalid && m_axis_tready.
- Output is first-word-fall-through from the head entry. A phit pushed on edge N is visible at m_axis_* after edge N (latency 1) when the FIFO was empty.
- Full: s_axis_tready = 0 even if a pop happens in the same cycle. There is no full-bypass.
- Empty: m_axis_tvalid = 0. There is no input-to-output combinational path.
- Simultaneous push and pop, not full and not empty: fifo_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Output stability:
- While m_axis_tvalid && !m_axis_tready, m_axis_tdata, tkeep and tlast are held stable.
- The FSM and beat counter advance only on a pop.

FSM:
- IDLE, no beat of the current packet sent yet.
  - On a pop: latch len = max(cfg_pkt_len, 1).
  - If the popped beat is last (see rule below): pkt_count++, stay in IDLE.
  - Otherwise: beat_cnt = 1, go to BODY.
- BODY.
  - On a pop: if the beat is last, go to IDLE, beat_cnt = 0, pkt_count++. Otherwise beat_cnt++.
- Last-beat rule: m_axis_tlast = (beat_cnt == len_eff - 1) || head.tlast.
  - len_eff is len in BODY and max(cfg_pkt_len, 1) in IDLE.
  - This is combinational from the registered state and the FIFO head.
- early_term_count++ on a pop where head.tlast = 1 and beat_cnt != len_eff - 1.
- Changing cfg_pkt_len mid-packet has no effect until the next packet.
- Counters wrap at 2^CNT_W. beat_cnt never exceeds len - 1.

Test Plan:
1. Reset release, cfg_pkt_len = 4, push 8 phits (data = index), m_axis_tready = 1 -> 8 output beats in order, tlast on beats 3 and 7, pkt_count = 2, first tvalid one cycle after the first push.
2. Fill with m_axis_tready = 0, FIFO_DEPTH = 16 -> s_axis_tready drops after the 16th accept, fifo_level = 16, tdata/tlast stable; raise tready -> drains, tready returns after the first pop.
3. cfg_pkt_len = 4, input tlast on the 2nd phit, then 4 more phits -> tlast on output beats 1 and 5, early_term_count = 1, pkt_count = 2.
4. cfg_pkt_len = 0 and = 1, push 3 phits -> tlast on every beat, pkt_count = 3.
5. Change cfg_pkt_len 4 -> 2 after beat 1 of a packet -> current packet still ends at beat 3, next packet is 2 beats.
6. Assert ap_rst asynchronously mid-packet with 5 entries queued -> all outputs and fifo_level = 0 immediately; after release, a new 4-beat packet frames from beat 0.
